glitch_sequencer: RTL and testbench

- Executes the glitch program held in the program ROM: drives the ROM instruction pointer and delay index, decodes each 12-bit instruction, and emits the glitch output pattern, programmed delays and trigger waits.
- Sits between the host start/abort controls and the glitch output drivers.
- The ROM is registered, with one-cycle read latency for both instruction and delay lookups.

---
 rtl/glitch_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// Glitch program sequencer: walks a registered program ROM (one-cycle read latency for both
// the instruction and the delay table) and drives glitch_out, programmed delays and trigger waits.
module glitch_sequencer #(
  parameter int unsigned PROG_LEN = 14,
  parameter int unsigned PT_W     = 8,
  parameter int unsigned OUT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             trig_in,
  input  logic [11:0]      instr,
  input  logic [31:0]      delay_len,
  output logic [PT_W-1:0]  instr_pt,
  output logic [PT_W-1:0]  delay_num,
  output logic [OUT_W-1:0] glitch_out,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StDsel, StDarm, StDcount, StTwait, StNext
  } state_e;

  typedef enum logic [1:0] {
    OpOut   = 2'b00,
    OpWait  = 2'b01,
    OpDelay = 2'b10,
    OpHalt  = 2'b11
  } op_e;

  state_e           state_q, state_d;
  logic [PT_W-1:0]  instr_pt_q, instr_pt_d;
  logic [PT_W-1:0]  delay_num_q, delay_num_d;
  logic [OUT_W-1:0] glitch_out_q, glitch_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [7:0]       edge_cnt_q, edge_cnt_d;
  logic             trig_d_q;
  logic             rom_ready_q;

  op_e         op;
  logic        en;
  logic        last;
  logic [7:0]  operand;
  logic [PT_W:0] ptr_next;
  logic        start_ok;
  logic        rise;
  logic        ptr_ovf;
  logic        halt_hit;
  logic        next_last;
  logic        next_ovf;
  logic        finish;

  assign op       = op_e'(instr[11:10]);
  assign en       = instr[9];
  assign operand  = instr[8:1];
  assign last     = instr[0];

  // The ROM spends its first post-reset cycle loading, so start is held off until then.
  assign start_ok = start & rom_ready_q & ~abort;
  assign rise     = trig_in & ~trig_d_q;
  assign ptr_next = {1'b0, instr_pt_q} + (PT_W+1)'(1);
  assign ptr_ovf  = ptr_next >= (PT_W+1)'(PROG_LEN);

  assign halt_hit  = (state_q == StDecode) & en & (op == OpHalt);
  assign next_last = (state_q == StNext) & last;
  assign next_ovf  = (state_q == StNext) & ~last & ptr_ovf;
  assign finish    = halt_hit | next_last | next_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StFetch;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (!en) begin
          state_d = StNext;
        end else begin
          unique case (op)
            OpOut:   state_d = StNext;
            OpDelay: state_d = StDsel;
            OpWait:  state_d = StTwait;
            OpHalt:  state_d = StIdle;
            default: state_d = StNext;
          endcase
        end
      end
      StDsel: state_d = StDarm;
      StDarm: state_d = (delay_len == 32'd0) ? StNext : StDcount;
      StDcount: begin
        if (cnt_q <= 32'd1) state_d = StNext;
      end
      StTwait: begin
        if (rise && edge_cnt_q <= 8'd1) state_d = StNext;
      end
      StNext: state_d = finish ? StIdle : StFetch;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_comb begin
    instr_pt_d   = instr_pt_q;
    delay_num_d  = delay_num_q;
    glitch_out_d = glitch_out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    cnt_d        = cnt_q;
    edge_cnt_d   = edge_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          instr_pt_d = '0;
          error_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StDecode: begin
        if (en) begin
          unique case (op)
            OpOut:   glitch_out_d = OUT_W'(operand);
            OpDelay: delay_num_d  = PT_W'(operand);
            OpWait:  edge_cnt_d   = (operand == 8'd0) ? 8'd1 : operand;
            OpHalt:  ;
            default: ;
          endcase
        end
      end
      StDarm: cnt_d = delay_len;
      StDcount: begin
        // Counter bottoms out at 1; the exit is taken on that cycle.
        if (cnt_q > 32'd1) cnt_d = cnt_q - 32'd1;
      end
      StTwait: begin
        if (rise && edge_cnt_q != 8'd0) edge_cnt_d = edge_cnt_q - 8'd1;
      end
      StNext: begin
        if (next_ovf) begin
          error_d = 1'b1;
        end else if (!finish) begin
          instr_pt_d = ptr_next[PT_W-1:0];
        end
      end
      default: ;
    endcase
    if (finish) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    // Abort freezes pointers and the error flag; only the pattern and busy are cleared.
    if (abort) begin
      instr_pt_d   = instr_pt_q;
      delay_num_d  = delay_num_q;
      glitch_out_d = '0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      error_d      = error_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_pt_q   <= '0;
      delay_num_q  <= '0;
      glitch_out_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cnt_q        <= '0;
      edge_cnt_q   <= '0;
      trig_d_q     <= 1'b0;
      rom_ready_q  <= 1'b0;
    end else begin
      instr_pt_q   <= instr_pt_d;
      delay_num_q  <= delay_num_d;
      glitch_out_q <= glitch_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cnt_q        <= cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      trig_d_q     <= trig_in;
      rom_ready_q  <= 1'b1;
    end
  end

  assign instr_pt   = instr_pt_q;
  assign delay_num  = delay_num_q;
  assign glitch_out = glitch_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: a table of one-word programs, directed multi-cycle corner cases
// and random programs checked against a cycle-budget model of the program.
module tb_glitch_sequencer;

  localparam int unsigned PROG_LEN = 14;
  localparam int H = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        trig_in = 1'b0;
  logic [11:0] instr;
  logic [31:0] delay_len;
  logic [7:0]  instr_pt, delay_num, glitch_out;
  logic        busy, done, error;

  logic [11:0] rom  [256];
  logic [31:0] dtab [256];
  logic        sched [H];
  logic [7:0]  exp_go   [H];
  logic        exp_busy [H];
  logic        exp_done [H];
  int          m_fin, m_pt;
  logic        m_err;
  logic [7:0]  go_now;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] word;
    logic [31:0] dlen;
    int          fin;
    logic [7:0]  go;
  } vec_t;
  vec_t tbl [8];

  glitch_sequencer #(.PROG_LEN(PROG_LEN), .PT_W(8), .OUT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .trig_in(trig_in),
    .instr(instr), .delay_len(delay_len), .instr_pt(instr_pt), .delay_num(delay_num),
    .glitch_out(glitch_out), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Registered program ROM and delay table.
  always @(posedge clk) begin
    instr     <= rom[instr_pt];
    delay_len <= dtab[delay_num];
  end

  function automatic logic [11:0] enc(input logic [1:0] op, input logic en,
                                      input logic [7:0] opd, input logic last);
    return {op, en, opd, last};
  endfunction

  function automatic logic rise(input int n);
    if (n == 0) return sched[0];
    return sched[n] && !sched[n-1];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = '0;
      dtab[i] = '0;
    end
    for (int n = 0; n < H; n++) sched[n] = 1'b0;
  endtask

  // Cycle n is the interval after the n-th edge following the start edge. Each word costs
  // fetch+decode, then: OUT/NOP one NEXT cycle, DELAY dsel+darm+len+next, WAIT until the k-th
  // trigger rise seen from the cycle after decode, HALT ends straight from decode.
  task automatic model(input logic [7:0] go0);
    int t, i, c, k, n, len, e;
    int ev_e[$];
    logic [7:0] ev_v[$];
    logic [11:0] w;
    logic [7:0] g;
    t = 0; i = 0; m_fin = -1; m_err = 1'b0;
    while (m_fin < 0) begin
      w = rom[i];
      c = t + 2;
      if (w[9]) begin
        case (w[11:10])
          2'b00: begin ev_e.push_back(t + 2); ev_v.push_back(w[8:1]); end
          2'b10: begin len = int'(dtab[w[8:1]]); c = t + 4 + len; end
          2'b01: begin
            k = (w[8:1] == 8'd0) ? 1 : int'(w[8:1]);
            n = t + 2;
            while (n < H - 8) begin
              if (rise(n)) begin
                k--;
                if (k == 0) break;
              end
              n++;
            end
            c = n + 1;
          end
          default: m_fin = t + 2;
        endcase
      end
      if (m_fin < 0) begin
        if (w[0]) m_fin = c + 1;
        else if (i + 1 >= int'(PROG_LEN)) begin m_err = 1'b1; m_fin = c + 1; end
        else begin i++; t = c + 1; end
      end
    end
    m_pt = i;
    g = go0; e = 0;
    for (int n2 = 0; n2 <= m_fin + 1; n2++) begin
      while (e < ev_e.size() && ev_e[e] <= n2) begin g = ev_v[e]; e++; end
      exp_go[n2]   = g;
      exp_busy[n2] = (n2 < m_fin);
      exp_done[n2] = (n2 == m_fin);
    end
  endtask

  task automatic run_prog(input logic [7:0] go0);
    model(go0);
    @(negedge clk);
    trig_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n <= m_fin + 1; n++) begin
      trig_in = sched[n];
      @(negedge clk);
      if (n == 0) begin
        check("fetch_pt", instr_pt, 0);
        check("err_clear", error, 0);
      end
      check($sformatf("glitch_out@%0d", n), glitch_out, exp_go[n]);
      check($sformatf("busy@%0d", n), busy, exp_busy[n]);
      check($sformatf("done@%0d", n), done, exp_done[n]);
      if (n == m_fin) begin
        check("error_at_finish", error, m_err);
        check("final_pt", instr_pt, m_pt);
      end
      @(posedge clk); #1;
    end
    trig_in = 1'b0;
    go_now = exp_go[m_fin + 1];
  endtask

  // Caller is at a negedge; ends #1 after the edge following the done cycle.
  task automatic apply_row(input vec_t v, input int idx);
    int got;
    rom[0] = v.word;
    dtab[v.word[8:1]] = v.dlen;
    trig_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = -1;
    for (int n = 0; n < 64 && got < 0; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check($sformatf("tbl%0d_busy", idx), busy, 1);
        check($sformatf("tbl%0d_fetch_pt", idx), instr_pt, 0);
      end
      if (done) got = n;
      @(posedge clk); #1;
    end
    check($sformatf("tbl%0d_done_cycle", idx), got, v.fin);
    check($sformatf("tbl%0d_glitch_out", idx), glitch_out, v.go);
    check($sformatf("tbl%0d_busy_after", idx), busy, 0);
    check($sformatf("tbl%0d_done_single", idx), done, 0);
    check($sformatf("tbl%0d_error", idx), error, 0);
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] opd;
    int r;

    tbl[0] = '{enc(2'b00, 1'b1, 8'h84, 1'b1), 32'd0, 3,  8'h84};
    tbl[1] = '{enc(2'b00, 1'b0, 8'h5A, 1'b1), 32'd0, 3,  8'h84};
    tbl[2] = '{enc(2'b11, 1'b1, 8'h00, 1'b0), 32'd0, 2,  8'h84};
    tbl[3] = '{enc(2'b00, 1'b1, 8'h3C, 1'b1), 32'd0, 3,  8'h3C};
    tbl[4] = '{enc(2'b10, 1'b1, 8'h02, 1'b1), 32'd0, 5,  8'h3C};
    tbl[5] = '{enc(2'b10, 1'b1, 8'h03, 1'b1), 32'd8, 13, 8'h3C};
    tbl[6] = '{enc(2'b10, 1'b1, 8'h04, 1'b1), 32'd1, 6,  8'h3C};
    tbl[7] = '{enc(2'b11, 1'b0, 8'hFF, 1'b1), 32'd0, 3,  8'h3C};

    clear_prog();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_instr_pt", instr_pt, 0);
    check("rst_delay_num", delay_num, 0);
    check("rst_glitch_out", glitch_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_ignored_rom_load", busy, 0);

    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      apply_row(tbl[i], i);
    end
    go_now = tbl[7].go;

    // OUT 0x84; OUT 0x01; DELAY idx0 (8); OUT 0x0F last.
    clear_prog();
    rom[0] = enc(2'b00, 1'b1, 8'h84, 1'b0);
    rom[1] = enc(2'b00, 1'b1, 8'h01, 1'b0);
    rom[2] = enc(2'b10, 1'b1, 8'h00, 1'b0);
    rom[3] = enc(2'b00, 1'b1, 8'h0F, 1'b1);
    dtab[0] = 32'd8;
    run_prog(go_now);

    // WAIT 2 with a held-high interval counting once.
    clear_prog();
    rom[0] = enc(2'b00, 1'b1, 8'h11, 1'b0);
    rom[1] = enc(2'b01, 1'b1, 8'h02, 1'b0);
    rom[2] = enc(2'b00, 1'b1, 8'h22, 1'b1);
    for (int n = 6; n <= 10; n++) sched[n] = 1'b1;
    sched[14] = 1'b1;
    run_prog(go_now);

    // Trigger already high before the wait starts is not an edge.
    for (int n = 0; n < H; n++) sched[n] = 1'b0;
    for (int n = 2; n <= 8; n++) sched[n] = 1'b1;
    sched[10] = 1'b1;
    sched[12] = 1'b1;
    run_prog(go_now);

    // No last bit anywhere: pointer overruns after word 13.
    clear_prog();
    for (int i = 0; i < 14; i++) rom[i] = enc(2'b00, 1'b1, 8'(i + 1), 1'b0);
    run_prog(go_now);

    // start with abort in the same cycle: abort wins, error left alone.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", busy, 0);
    check("start_abort_error_kept", error, 1);
    check("start_abort_glitch", glitch_out, 0);
    go_now = 8'h00;

    // Abort during a long delay.
    clear_prog();
    rom[0] = enc(2'b00, 1'b1, 8'hA5, 1'b0);
    rom[1] = enc(2'b10, 1'b1, 8'h03, 1'b1);
    dtab[3] = 32'h0402EAA0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("restart_clears_error", error, 0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("dcount_busy", busy, 1);
    check("dcount_glitch", glitch_out, 8'hA5);
    check("dcount_delay_num", delay_num, 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("abort_glitch@%0d", k), glitch_out, 0);
      check($sformatf("abort_busy@%0d", k), busy, 0);
      check($sformatf("abort_no_done@%0d", k), done, 0);
    end
    check("abort_error", error, 0);

    // Back in idle: a fresh program runs normally.
    clear_prog();
    rom[0] = enc(2'b00, 1'b1, 8'h5C, 1'b1);
    run_prog(go_now);

    // Reset mid-WAIT.
    clear_prog();
    rom[0] = enc(2'b00, 1'b1, 8'h77, 1'b0);
    rom[1] = enc(2'b10, 1'b1, 8'h05, 1'b0);
    rom[2] = enc(2'b01, 1'b1, 8'h03, 1'b1);
    dtab[5] = 32'd2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("twait_busy", busy, 1);
    check("twait_glitch", glitch_out, 8'h77);
    check("twait_delay_num", delay_num, 5);
    check("twait_pt", instr_pt, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_instr_pt", instr_pt, 0);
    check("mid_rst_delay_num", delay_num, 0);
    check("mid_rst_glitch_out", glitch_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_ignored_after_reset", busy, 0);
    go_now = 8'h00;

    // Random programs; the trigger pattern guarantees a rise every 8 cycles.
    for (int p = 0; p < 30; p++) begin
      clear_prog();
      for (int i = 0; i < 14; i++) begin
        r = int'($urandom_range(0, 15));
        opd = 8'($urandom_range(0, 255));
        if (r == 0) op = 2'b11;
        else if (r < 7) op = 2'b00;
        else if (r < 11) begin op = 2'b10; opd = opd & 8'h07; end
        else begin op = 2'b01; opd = opd & 8'h03; end
        rom[i] = enc(op, $urandom_range(0, 7) != 0, opd, $urandom_range(0, 11) == 0);
      end
      for (int d = 0; d < 8; d++) dtab[d] = 32'($urandom_range(0, 12));
      for (int n = 0; n < H; n++) begin
        if (n % 8 == 3) sched[n] = 1'b0;
        else if (n % 8 == 4) sched[n] = 1'b1;
        else sched[n] = 1'($urandom_range(0, 1));
      end
      run_prog(go_now);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
